// File: rtl/ms_pkg.sv
// ms_pkg -- shared constants for the millisecond pulse monitor.
//   * default parameter values for ms_pulse_monitor
//   * FSM state encodings (IDLE / ARM / MEASURE)
//   * helpers that derive the in-spec window bounds without wrapping
package ms_pkg;

    // Default parameter values: 50 MHz clock, +/-1% window, 4-period lock.
    localparam int MS_CYCLES_PER_MS = 50000;
    localparam int MS_TOL           = 500;
    localparam int MS_LOCK_N        = 4;
    localparam int MS_CNT_W         = 20;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;

    // Lower window bound, clamped at zero so a large tolerance cannot
    // wrap the unsigned compare.
    function automatic longint window_lo(input longint cpm, input longint tol);
        return (tol > cpm) ? 64'sd0 : (cpm - tol);
    endfunction

    // Upper window bound, clamped to the largest value the counter can hold.
    function automatic longint window_hi(input longint cpm, input longint tol,
                                         input int w);
        longint top;
        longint sum;
        top = (64'sd1 <<< w) - 64'sd1;
        sum = cpm + tol;
        return (sum > top) ? top : sum;
    endfunction

endpackage

// File: rtl/sync_rise.sv
// sync_rise -- brings an asynchronous input into the clk domain and emits a
// one-cycle strobe on each rising edge.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low
//   d     : asynchronous input
//   rise  : registered one-cycle strobe, high 3 clk edges after d goes high
module sync_rise (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic meta;   // first synchronizer stage, may go metastable
    logic sync;   // second stage, safe to use
    logic last;   // previous synchronized value for edge detect

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            last <= 1'b0;
            rise <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
            last <= sync;
            rise <= sync & ~last;
        end
    end

endmodule

// File: rtl/ms_pulse_monitor.sv
// ms_pulse_monitor -- measures the rising-to-rising period of a nominal 1 ms
// pulse train, flags whether each period is inside the tolerance window,
// reports loss of pulses, and lights an LED after LOCK_N good periods in a row.
//   clk          : sole clock, rising edge
//   reset        : asynchronous, active-low
//   pulse_in     : asynchronous pulse train under test
//   start        : arm measurement (level, honoured only in IDLE)
//   stop         : return to IDLE (level, highest priority)
//   period       : last measured period in clk cycles
//   period_valid : one-cycle strobe when period is updated
//   in_spec      : last period within CYCLES_PER_MS +/- TOL inclusive
//   timeout      : one-cycle strobe, no edge for 2*CYCLES_PER_MS cycles
//   led          : high while locked
// CNT_W must be wide enough to hold 2*CYCLES_PER_MS.
module ms_pulse_monitor
    import ms_pkg::*;
#(
    parameter int CYCLES_PER_MS = MS_CYCLES_PER_MS,
    parameter int TOL           = MS_TOL,
    parameter int LOCK_N        = MS_LOCK_N,
    parameter int CNT_W         = MS_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic             start,
    input  logic             stop,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             in_spec,
    output logic             timeout,
    output logic             led
);

    localparam int LOCK_W = $clog2(LOCK_N + 1);

    localparam logic [CNT_W-1:0]  WIN_LO      = CNT_W'(window_lo(CYCLES_PER_MS, TOL));
    localparam logic [CNT_W-1:0]  WIN_HI      = CNT_W'(window_hi(CYCLES_PER_MS, TOL, CNT_W));
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(2 * CYCLES_PER_MS);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [LOCK_W-1:0] LOCK_MAX    = LOCK_W'(LOCK_N);

    logic              rise;
    logic [1:0]        state,     state_nxt;
    logic [CNT_W-1:0]  cnt,       cnt_nxt;
    logic [CNT_W-1:0]  period_nxt;
    logic              pv_nxt;
    logic              ins_nxt;
    logic              to_nxt;
    logic [LOCK_W-1:0] lock_cnt,  lock_nxt;
    logic              cnt_ok;

    sync_rise u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pulse_in),
        .rise  (rise)
    );

    // The count at the moment of a rise is the full period: the counter is
    // loaded with 1 on the edge that sees a rise, so after N cycles it reads N.
    assign cnt_ok = (cnt >= WIN_LO) && (cnt <= WIN_HI);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        period_nxt = period;
        pv_nxt     = 1'b0;
        ins_nxt    = in_spec;
        to_nxt     = 1'b0;
        lock_nxt   = lock_cnt;

        if (stop) begin
            // stop beats start and rise; the period in flight is dropped
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            lock_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_nxt = '0;
                    if (start)
                        state_nxt = ST_ARM;
                end
                ST_ARM: begin
                    // first edge only opens the measurement window
                    cnt_nxt = '0;
                    if (rise) begin
                        state_nxt = ST_MEASURE;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        period_nxt = cnt;
                        pv_nxt     = 1'b1;
                        ins_nxt    = cnt_ok;
                        cnt_nxt    = CNT_W'(1);
                        if (cnt_ok)
                            lock_nxt = (lock_cnt == LOCK_MAX) ? lock_cnt
                                                              : lock_cnt + LOCK_W'(1);
                        else
                            lock_nxt = '0;
                    end else if (cnt >= TIMEOUT_CNT) begin
                        // pulses lost: rearm and wait for a fresh first edge
                        to_nxt    = 1'b1;
                        state_nxt = ST_ARM;
                        cnt_nxt   = '0;
                        ins_nxt   = 1'b0;
                        lock_nxt  = '0;
                    end else if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            in_spec      <= 1'b0;
            timeout      <= 1'b0;
            lock_cnt     <= '0;
            led          <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            period       <= period_nxt;
            period_valid <= pv_nxt;
            in_spec      <= ins_nxt;
            timeout      <= to_nxt;
            lock_cnt     <= lock_nxt;
            // led tracks the next lock count so it drops on the same edge
            // as the strobe or transition that broke the lock
            led          <= (lock_nxt == LOCK_MAX);
        end
    end

endmodule

// File: tb/tb_ms_pulse_monitor.sv
// tb_ms_pulse_monitor -- scoreboard bench for ms_pulse_monitor with a
// 100-cycle nominal period, +/-2 tolerance and 4-period lock.
module tb_ms_pulse_monitor;

    localparam int CPM   = 100;
    localparam int TOLV  = 2;
    localparam int LOCKN = 4;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          pulse_in;
    logic          start;
    logic          stop;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          in_spec;
    logic          timeout;
    logic          led;

    typedef struct {
        bit            is_to;
        logic [CW-1:0] per;
        bit            ins;
        bit            led;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_pv_cyc = 0;

    // reference model state
    bit            armed = 0;
    bit            meas  = 0;
    int            lock_m = 0;
    int            last_gap = 0;
    logic [CW-1:0] last_per = '0;

    ms_pulse_monitor #(
        .CYCLES_PER_MS (CPM),
        .TOL           (TOLV),
        .LOCK_N        (LOCKN),
        .CNT_W         (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pulse_in     (pulse_in),
        .start        (start),
        .stop         (stop),
        .period       (period),
        .period_valid (period_valid),
        .in_spec      (in_spec),
        .timeout      (timeout),
        .led          (led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_pv(input int per);
        exp_t e;
        e.is_to = 1'b0;
        e.per   = CW'(per);
        e.ins   = (per >= CPM - TOLV) && (per <= CPM + TOLV);
        if (e.ins) lock_m = (lock_m < LOCKN) ? lock_m + 1 : LOCKN;
        else       lock_m = 0;
        e.led   = (lock_m == LOCKN);
        last_per = e.per;
        sb.push_back(e);
    endtask

    // Raise pulse_in now and spend gap cycles; next call rises gap cycles later.
    // mode 1: pulse start mid-period; mode 2: stop coincident with this rise.
    task automatic send(input int gap, input int mode);
        if (mode == 2) begin
            armed = 0; meas = 0; lock_m = 0;
        end else if (armed) begin
            if (meas) push_pv(last_gap);
            meas = 1;
        end
        last_gap = gap;
        pulse_in = 1'b1;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            if (i == 2) pulse_in = 1'b0;
            stop  = (mode == 2 && i == 2);
            start = (mode == 1 && i == 10);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (!armed) begin armed = 1; meas = 0; end
    endtask

    task automatic hold_low(input int n);
        exp_t e;
        if (meas) begin
            e.is_to = 1'b1; e.per = last_per; e.ins = 1'b0; e.led = 1'b0;
            sb.push_back(e);
        end
        meas = 0; lock_m = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // output monitor: pops an expectation for every strobe the DUT produces
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (period_valid) begin
                if (sb.size() == 0) chk("pv_unexpected", 32'(period_valid), 0);
                else begin
                    e = sb.pop_front();
                    chk("pv_kind",   32'(e.is_to), 0);
                    chk("pv_period", 32'(period), 32'(e.per));
                    chk("pv_in_spec",32'(in_spec), 32'(e.ins));
                    chk("pv_led",    32'(led), 32'(e.led));
                end
                last_pv_cyc = cyc;
            end
            if (timeout) begin
                if (sb.size() == 0) chk("to_unexpected", 32'(timeout), 0);
                else begin
                    e = sb.pop_front();
                    chk("to_kind",   32'(e.is_to), 1);
                    chk("to_period", 32'(period), 32'(e.per));
                    chk("to_in_spec",32'(in_spec), 0);
                    chk("to_led",    32'(led), 0);
                    chk("to_delay",  32'(cyc - last_pv_cyc), 32'(2 * CPM));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; pulse_in = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_period", 32'(period), 0);
        chk("rst_pv",     32'(period_valid), 0);
        chk("rst_in_spec",32'(in_spec), 0);
        chk("rst_timeout",32'(timeout), 0);
        chk("rst_led",    32'(led), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // nominal train, lock after the 4th valid; start mid-measure ignored
        do_start();
        send(100, 0); send(100, 0); send(100, 1); send(100, 0); send(100, 0); send(100, 0);
        chk("led_locked", 32'(led), 1);

        // one long period breaks lock, four good ones relock
        send(103, 0);
        for (int k = 0; k < 5; k++) send(100, 0);
        chk("led_relocked", 32'(led), 1);

        // pulses vanish: timeout, rearm, then a 98-cycle period
        hold_low(150);
        send(98, 0); send(100, 0);

        // window boundaries
        send(102, 0); send(97, 0); send(103, 0); send(100, 0);

        // stop coincident with a rise, then pulses while idle
        send(100, 2);
        chk("led_after_stop", 32'(led), 0);
        send(100, 0); send(100, 0);

        // start and stop together keep the block idle
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        send(100, 0); send(100, 0); send(100, 0);
        chk("led_start_stop", 32'(led), 0);

        // lock, then reset mid-period
        do_start();
        for (int k = 0; k < 6; k++) send(100, 0);
        chk("led_before_rst", 32'(led), 1);
        repeat (40) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_period", 32'(period), 0);
        chk("arst_in_spec",32'(in_spec), 0);
        chk("arst_led",    32'(led), 0);
        chk("arst_pv",     32'(period_valid), 0);
        chk("arst_timeout",32'(timeout), 0);
        armed = 0; meas = 0; lock_m = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        send(100, 0); send(100, 0);
        do_start();
        send(100, 0); send(99, 0); send(100, 0);

        repeat (20) @(posedge clk); #1;
        chk("sb_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ms_pulse_monitor.md
MS_PULSE_MONITOR -- requirements
Module: ms_pulse_monitor

Interface
REQ-001 SHALL have parameter CYCLES_PER_MS, default 50000, clk cycles in one nominal millisecond period.
REQ-002 SHALL have parameter TOL, default 500, allowed +/- deviation in cycles for an in-spec period.
REQ-003 SHALL have parameter LOCK_N, default 4, number of consecutive in-spec periods needed to declare lock.
REQ-004 SHALL have parameter CNT_W, default 20, period counter width; CNT_W SHALL hold 2*CYCLES_PER_MS.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port pulse_in  input  1  asynchronous millisecond pulse train under test.
REQ-008 SHALL have port start  input  1  arm measurement, level-sampled each cycle.
REQ-009 SHALL have port stop  input  1  halt measurement, level-sampled each cycle.
REQ-010 SHALL have port period  output  CNT_W  last measured rising-to-rising period in clk cycles.
REQ-011 SHALL have port period_valid  output  1  one-cycle strobe marking a new period value.
REQ-012 SHALL have port in_spec  output  1  last period within CYCLES_PER_MS +/- TOL, inclusive.
REQ-013 SHALL have port timeout  output  1  one-cycle strobe: no rising edge for 2*CYCLES_PER_MS cycles.
REQ-014 SHALL have port led  output  1  lock indicator, high while locked.

Function
REQ-015 SHALL pass pulse_in through a 2-flop synchronizer, then a rising-edge detector producing a one-cycle strobe rise; rise occurs 3 clk edges after pulse_in goes high.
REQ-016 SHALL implement FSM states IDLE, ARM, MEASURE.
REQ-017 IDLE: counter held at 0; start=1 and stop=0 -> ARM.
REQ-018 ARM: rise -> MEASURE with counter loaded to 1; no period_valid on this first edge.
REQ-019 MEASURE: counter increments by 1 per cycle; on rise, period <= counter, counter <= 1, state stays MEASURE.
REQ-020 period_valid SHALL be high exactly one cycle, the cycle after the rise strobe, with period and in_spec updated on that same edge.
REQ-021 in_spec SHALL be 1 iff CYCLES_PER_MS-TOL <= period <= CYCLES_PER_MS+TOL; unsigned compare, no wrap.
REQ-022 MEASURE: counter reaching 2*CYCLES_PER_MS without rise -> timeout strobe one cycle, state -> ARM, period unchanged, in_spec <= 0.
REQ-023 counter SHALL never wrap; it saturates at 2^CNT_W-1.
REQ-024 stop=1 in any state -> IDLE next cycle; stop wins over simultaneous start or rise; no period_valid or timeout generated that cycle.
REQ-025 start while in ARM or MEASURE SHALL be ignored.
REQ-026 lock counter SHALL increment on each in-spec period_valid, saturating at LOCK_N; led=1 iff count == LOCK_N.
REQ-027 out-of-spec period_valid, timeout, or stop SHALL clear lock counter and led in the same cycle as that event's strobe/transition.

Reset
REQ-028 reset low SHALL asynchronously force: state IDLE, synchronizer and edge flops 0, counter 0, period 0, period_valid 0, in_spec 0, timeout 0, lock counter 0, led 0.
REQ-029 reset release SHALL take effect synchronously; first state change no earlier than the first clk edge after release.
REQ-030 reset asserted mid-measurement SHALL discard the partial period; no strobe emitted.

Structure
REQ-031 SHALL place the FSM state enumeration and default parameter constants in shared package ms_pkg, alongside mspulse constants.
REQ-032 SHALL implement synchronizer plus edge detect as sub-module sync_rise (inputs clk, reset, d; output rise).
REQ-033 Counter, FSM, compare and lock logic SHALL live in ms_pulse_monitor; no latches; all outputs registered.

Verification (CYCLES_PER_MS=100, TOL=2, LOCK_N=4, CNT_W=8)
REQ-034 start, pulse_in rising every 100 cycles -> period_valid per edge after the first, period=100, in_spec=1, led=1 after 4th valid.
REQ-035 locked, then one period of 103 cycles -> period=103, in_spec=0, led=0 same cycle; 4 more 100-cycle periods relock.
REQ-036 locked, pulse_in held low -> timeout strobe 200 cycles after last rise counter load, led=0, state ARM; next two edges 98 apart -> period=98, in_spec=1.
REQ-037 start and stop high same cycle, and stop coincident with rise -> state IDLE, no period_valid, led=0.
REQ-038 reset pulsed low mid-period while locked -> all outputs 0 immediately (async); after release, start required; first edge yields no period_valid.
REQ-039 boundary periods 98, 102, 97, 103 -> in_spec 1, 1, 0, 0.
